// File: rtl/sync_event_logger_if.sv
// Bus interface for sync_event_logger.
// Groups the event inputs, the control strobes and the host read port of the logger.
//   master : host/firmware side, drives events, mask, arm, clr and rd_en
//   slave  : logger side, returns rd_valid, rd_data, level, overflow count and timestamp
interface sync_event_logger_if #(
    parameter int unsigned EVT_WIDTH  = 17,
    parameter int unsigned TS_WIDTH   = 32,
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [EVT_WIDTH-1:0]          io_evt_in;
    logic [EVT_WIDTH-1:0]          io_evt_mask;
    logic                          io_arm;
    logic                          io_clr;
    logic                          io_rd_en;
    logic                          io_rd_valid;
    logic [TS_WIDTH+EVT_WIDTH-1:0] io_rd_data;
    logic [DEPTH_LOG2:0]           io_level;
    logic [15:0]                   io_overflow_cnt;
    logic [TS_WIDTH-1:0]           io_ts_now;

    modport master (
        output io_evt_in, io_evt_mask, io_arm, io_clr, io_rd_en,
        input  io_rd_valid, io_rd_data, io_level, io_overflow_cnt, io_ts_now
    );

    modport slave (
        input  io_evt_in, io_evt_mask, io_arm, io_clr, io_rd_en,
        output io_rd_valid, io_rd_data, io_level, io_overflow_cnt, io_ts_now
    );
endinterface

// File: rtl/sync_event_logger.sv
// Timestamped rising-edge logger for the sync-trigger and working-feedback event lines.
// Rising edges on unmasked lines are stamped with a free-running counter and queued as
// {timestamp, edge vector} in a first-word-fall-through FIFO that firmware drains.
// Ports:
//   io_clk   : clock, all state on rising edge
//   io_rst_n : asynchronous active-low reset
//   bus      : slave side of sync_event_logger_if (events, mask, arm, clr, read port,
//              level, overflow count, current timestamp)
module sync_event_logger #(
    parameter int unsigned EVT_WIDTH  = 17,
    parameter int unsigned TS_WIDTH   = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input logic                io_clk,
    input logic                io_rst_n,
    sync_event_logger_if.slave bus
);
    localparam int unsigned EntryWidth = TS_WIDTH + EVT_WIDTH;
    localparam int unsigned Depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LevelFull = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [EVT_WIDTH-1:0]  evt_q, evt_d;
    logic                  prime_q, prime_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [15:0]           ovf_q, ovf_d;
    logic [EntryWidth-1:0] mem_q [Depth];

    logic [EVT_WIDTH-1:0] edges;
    logic                 full;
    logic                 pop;
    logic                 wr_req;
    logic                 wr_acc;

    always_comb begin
        edges  = bus.io_evt_in & ~evt_q & bus.io_evt_mask;
        full   = (level_q == LevelFull);
        pop    = (level_q != '0) & bus.io_rd_en & ~bus.io_clr;
        // No logging until the history has been loaded once, so lines already high
        // at reset release or after a clear never look like fresh edges.
        wr_req = prime_q & bus.io_arm & ~bus.io_clr & (edges != '0);
        // A pop in the same cycle frees the slot the write needs.
        wr_acc = wr_req & (~full | pop);

        evt_d    = bus.io_evt_in;
        prime_d  = ~bus.io_clr;
        ts_d     = ts_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (bus.io_clr) begin
            ts_d     = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = '0;
        end else begin
            if (bus.io_arm) begin
                ts_d = ts_q + 1'b1;
            end
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_acc, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (wr_req && !wr_acc && (ovf_q != 16'hFFFF)) begin
                ovf_d = ovf_q + 1'b1;
            end
        end
    end

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            evt_q    <= '0;
            prime_q  <= 1'b0;
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= '0;
        end else begin
            evt_q    <= evt_d;
            prime_q  <= prime_d;
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is only exposed while the FIFO is non-empty.
    always_ff @(posedge io_clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= {ts_q, edges};
        end
    end

    assign bus.io_rd_valid     = (level_q != '0);
    assign bus.io_rd_data      = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.io_level        = level_q;
    assign bus.io_overflow_cnt = ovf_q;
    assign bus.io_ts_now       = ts_q;
endmodule

// File: tb/tb_sync_event_logger.sv
// Self-checking bench for sync_event_logger: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_sync_event_logger;
    localparam int unsigned EW    = 17;
    localparam int unsigned TW    = 32;
    localparam int unsigned DL    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [EW-1:0] ONES = '1;

    typedef logic [TW+EW-1:0] entry_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_event_logger_if #(.EVT_WIDTH(EW), .TS_WIDTH(TW), .DEPTH_LOG2(DL)) bus ();

    sync_event_logger #(.EVT_WIDTH(EW), .TS_WIDTH(TW), .DEPTH_LOG2(DL)) dut (
        .io_clk  (clk),
        .io_rst_n(rst_n),
        .bus     (bus)
    );

    // Reference model state
    entry_t        m_q[$];
    logic [TW-1:0] m_ts     = '0;
    logic [15:0]   m_ovf    = '0;
    logic [EW-1:0] m_prev   = '0;
    bit            m_primed = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        entry_t head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        chk("level",    64'(bus.io_level),        64'(m_q.size()));
        chk("rd_valid", 64'(bus.io_rd_valid),     64'(m_q.size() != 0));
        chk("rd_data",  64'(bus.io_rd_data),      64'(head));
        chk("ovf_cnt",  64'(bus.io_overflow_cnt), 64'(m_ovf));
        chk("ts_now",   64'(bus.io_ts_now),       64'(m_ts));
    endtask

    // Cycle semantics written from the block's rules: pop the head, append the entry if
    // there is room, otherwise count a drop.
    task automatic model_update(input logic [EW-1:0] evt, input logic [EW-1:0] mask,
                                input bit arm, input bit clr, input bit rd_en);
        logic [EW-1:0] edges;
        edges = evt & ~m_prev & mask;
        if (clr) begin
            m_q.delete();
            m_ts     = '0;
            m_ovf    = '0;
            m_primed = 1'b0;
        end else begin
            if (rd_en && m_q.size() != 0) void'(m_q.pop_front());
            if (m_primed && arm && edges != '0) begin
                if (m_q.size() < DEPTH) m_q.push_back({m_ts, edges});
                else if (m_ovf != 16'hFFFF) m_ovf++;
            end
            if (arm) m_ts++;
            m_primed = 1'b1;
        end
        m_prev = evt;
    endtask

    // Called just after a falling edge: drive, compare, clock, advance model.
    task automatic step(input logic [EW-1:0] evt, input logic [EW-1:0] mask, input bit arm,
                        input bit clr, input bit rd_en);
        bus.io_evt_in   = evt;
        bus.io_evt_mask = mask;
        bus.io_arm      = arm;
        bus.io_clr      = clr;
        bus.io_rd_en    = rd_en;
        #1;
        check_model();
        @(posedge clk);
        model_update(evt, mask, arm, clr, rd_en);
        @(negedge clk);
    endtask

    initial begin
        entry_t        newest;
        logic [TW-1:0] ts_hold;
        logic [EW-1:0] r_evt;
        logic [EW-1:0] r_mask;

        // Test 1: line 0 high and armed through reset release
        bus.io_evt_in   = 17'h00001;
        bus.io_evt_mask = ONES;
        bus.io_arm      = 1'b1;
        bus.io_clr      = 1'b0;
        bus.io_rd_en    = 1'b0;
        repeat (3) @(negedge clk);
        check_model();
        chk("rst_level", 64'(bus.io_level), 64'd0);
        chk("rst_valid", 64'(bus.io_rd_valid), 64'd0);
        rst_n = 1'b1;
        repeat (5) step(17'h00001, ONES, 1'b1, 1'b0, 1'b0);
        chk("t1_ts", 64'(bus.io_ts_now), 64'd5);
        chk("t1_level", 64'(bus.io_level), 64'd0);

        // Test 2: clear, prime while disarmed, then arm from ts = 0
        step('0, ONES, 1'b0, 1'b1, 1'b0);
        step('0, ONES, 1'b0, 1'b0, 1'b0);
        chk("t2_ts0", 64'(bus.io_ts_now), 64'd0);
        for (int i = 0; i < 20 && m_ts != 32'd10; i++) step('0, ONES, 1'b1, 1'b0, 1'b0);
        step(17'h00008, ONES, 1'b1, 1'b0, 1'b0);
        chk("t2_valid1", 64'(bus.io_rd_valid), 64'd1);
        chk("t2_entry1", 64'(bus.io_rd_data), 64'({32'd10, 17'h00008}));
        for (int i = 0; i < 20 && m_ts != 32'd20; i++) step('0, ONES, 1'b1, 1'b0, 1'b0);
        step(17'h10100, ONES, 1'b1, 1'b0, 1'b0);
        chk("t2_level", 64'(bus.io_level), 64'd2);
        step('0, ONES, 1'b1, 1'b0, 1'b1);
        chk("t2_entry2", 64'(bus.io_rd_data), 64'({32'd20, 17'h10100}));
        step('0, ONES, 1'b1, 1'b0, 1'b1);
        chk("t2_empty", 64'(bus.io_rd_valid), 64'd0);
        step('0, ONES, 1'b1, 1'b0, 1'b1);  // read while empty

        // Test 3: 20 isolated edges, no reads
        for (int i = 0; i < 20; i++) begin
            step(17'h00004, ONES, 1'b1, 1'b0, 1'b0);
            step('0, ONES, 1'b1, 1'b0, 1'b0);
        end
        chk("t3_level", 64'(bus.io_level), 64'd16);
        chk("t3_ovf", 64'(bus.io_overflow_cnt), 64'd4);

        // Test 4: write and pop together while full
        newest = {m_ts, 17'h00004};
        step(17'h00004, ONES, 1'b1, 1'b0, 1'b1);
        chk("t4_level", 64'(bus.io_level), 64'd16);
        chk("t4_ovf", 64'(bus.io_overflow_cnt), 64'd4);
        for (int i = 0; i < 15; i++) step('0, ONES, 1'b1, 1'b0, 1'b1);
        chk("t4_tail", 64'(bus.io_rd_data), 64'(newest));
        step('0, ONES, 1'b1, 1'b0, 1'b1);
        chk("t4_drained", 64'(bus.io_level), 64'd0);

        // Test 5: masked line, disarmed edge, re-arm with line still high
        step(17'h00001, ~17'h00001, 1'b1, 1'b0, 1'b0);
        step('0, ~17'h00001, 1'b1, 1'b0, 1'b0);
        step(17'h00001, ~17'h00001, 1'b1, 1'b0, 1'b0);
        step('0, ~17'h00001, 1'b0, 1'b0, 1'b0);
        ts_hold = m_ts;
        step(17'h00002, ~17'h00001, 1'b0, 1'b0, 1'b0);
        step(17'h00002, ~17'h00001, 1'b0, 1'b0, 1'b0);
        chk("t5_ts_frozen", 64'(bus.io_ts_now), 64'(ts_hold));
        step(17'h00002, ~17'h00001, 1'b1, 1'b0, 1'b0);
        chk("t5_level", 64'(bus.io_level), 64'd0);
        chk("t5_ts_run", 64'(bus.io_ts_now), 64'(ts_hold + 32'd1));

        // Test 6: clear with level 5 and two drops outstanding
        step('0, ONES, 1'b1, 1'b1, 1'b0);
        step('0, ONES, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            step(17'h00004, ONES, 1'b1, 1'b0, 1'b0);
            step('0, ONES, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 11; i++) step('0, ONES, 1'b1, 1'b0, 1'b1);
        chk("t6_level5", 64'(bus.io_level), 64'd5);
        chk("t6_ovf2", 64'(bus.io_overflow_cnt), 64'd2);
        step(17'h00008, ONES, 1'b1, 1'b1, 1'b1);
        chk("t6_level0", 64'(bus.io_level), 64'd0);
        chk("t6_ovf0", 64'(bus.io_overflow_cnt), 64'd0);
        chk("t6_ts0", 64'(bus.io_ts_now), 64'd0);
        chk("t6_valid0", 64'(bus.io_rd_valid), 64'd0);
        step(17'h00008, ONES, 1'b1, 1'b0, 1'b0);
        step(17'h00008, ONES, 1'b1, 1'b0, 1'b0);
        chk("t6_no_log", 64'(bus.io_level), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r_evt  = EW'($urandom) & EW'($urandom) & EW'($urandom);
            r_mask = ($urandom_range(0, 7) == 0) ? EW'($urandom) : ONES;
            step(r_evt, r_mask, $urandom_range(0, 9) != 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 2) == 0);
        end
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sync_event_logger.md
Name: sync_event_logger

Overview:
- Downstream consumer of the sync-trigger logic top. Edge-detects the synchronous trigger outputs and the working-feedback pulses (8 + 9 = 17 event lines).
- Timestamps each event cycle against a free-running counter and queues {timestamp, event vector} in a first-word-fall-through FIFO.
- Host firmware drains the FIFO through bus registers. The block turns the one-cycle working-feedback pulses and trigger pulse edges into a readable event history for timing verification in the field.

Parameters:
- EVT_WIDTH, 17, number of event lines (syncTrig pulse outputs [7:0], workingFb [16:8]).
- TS_WIDTH, 32, timestamp counter width in io_clk cycles.
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 entries.

Ports:
- io_clk  in  1  system clock, all logic on rising edge
- io_rst_n  in  1  reset, asynchronous assert, active-low
- io_evt_in  in  EVT_WIDTH  event lines, level, synchronous to io_clk
- io_evt_mask  in  EVT_WIDTH  1 = line participates in edge detection
- io_arm  in  1  level; 1 = timestamp runs and events are logged
- io_clr  in  1  single-cycle pulse; flush FIFO, zero timestamp and overflow count
- io_rd_en  in  1  pop head entry (ignored when io_rd_valid = 0)
- io_rd_valid  out  1  FIFO not empty
- io_rd_data  out  TS_WIDTH+EVT_WIDTH  head entry {timestamp[MSBs], event vector[LSBs]}; valid when io_rd_valid = 1
- io_level  out  DEPTH_LOG2+1  current entry count, 0..2^DEPTH_LOG2
- io_overflow_cnt  out  16  entries dropped because FIFO full, saturating
- io_ts_now  out  TS_WIDTH  current timestamp counter

Behaviour:
- Reset (io_rst_n = 0, asynchronous):
  - FIFO pointers, io_level, io_overflow_cnt, io_ts_now all clear to 0.
  - io_rd_valid = 0, io_rd_data = 0, edge history = 0, prime flag = 0.
- Priming:
  - The first io_clk edge after reset release (and the first after io_clr) loads the edge history from io_evt_in and sets prime = 1. No logging occurs on that edge.
  - Consequence: lines already high at reset release never produce a spurious event.
- Edge detection:
  - evt_q is registered from io_evt_in every cycle, regardless of io_arm.
  - edges = io_evt_in & ~evt_q & io_evt_mask, computed combinationally.
  - Pulse width is irrelevant: a 1-cycle pulse and a long level each yield exactly one edge.
- Timestamp:
  - io_ts_now increments by 1 per cycle while io_arm = 1 and io_clr = 0, and holds while io_arm = 0.
  - Wraps from all-ones to 0 with no flag.
- Write:
  - Occurs when prime = 1, io_arm = 1, io_clr = 0 and edges != 0.
  - Entry = {io_ts_now before the increment, edges}.
  - Written on the same rising edge that samples the events; io_rd_valid rises 1 cycle after the event is visible on io_evt_in.
  - Simultaneous edges on several lines form one entry with multiple bits set.
- Read (FWFT):
  - io_rd_data always presents the head entry. When io_rd_valid = 1, io_rd_en pops the head on the next rising edge.
  - io_rd_en while empty: no effect, no error.
- Full:
  - Write with io_level = 2^DEPTH_LOG2 and no pop in the same cycle: entry dropped, io_overflow_cnt += 1, saturating at 16'hFFFF.
  - Write and pop in the same cycle while full: both occur, io_level stays full, no drop.
- Empty: write and io_rd_en in the same cycle. The pop is ignored because io_rd_valid was 0; the write lands and io_level becomes 1.
- io_level: +1 on accepted write only, −1 on accepted pop only, unchanged when both or neither occur.
- io_clr (highest priority, synchronous):
  - On the next edge: pointers, io_level, io_ts_now and io_overflow_cnt go to 0, and prime goes to 0.
  - Any events or reads in the io_clr cycle are discarded; re-prime occurs on the following cycle.
- io_arm falling:
  - Entries in flight are already stored; the FIFO remains readable.
  - Edge history keeps tracking, so re-arming logs only new edges.
- Storage:
  - Register or distributed RAM, 2^DEPTH_LOG2 × (TS_WIDTH+EVT_WIDTH).
  - Pointers are DEPTH_LOG2 bits and wrap naturally.
  - Full/empty are derived from io_level, not from pointer compare alone.

Test Plan:
1. Reset release with io_evt_in = 17'h00001 and io_arm = 1 held from reset → no entry written, io_level = 0 after 5 cycles, io_ts_now = 5.
2. Arm at ts = 0. Pulse bit 3 for 1 cycle when io_ts_now = 10, and bits 8 and 16 together at io_ts_now = 20 → two entries {10, 17'h00008} and {20, 17'h10100}, io_rd_valid one cycle after each, io_level = 2.
3. With DEPTH_LOG2 = 4, generate 20 isolated edges without reading → io_level = 16, io_overflow_cnt = 4, the first 16 timestamps are retained in order.
4. Full FIFO: assert io_rd_en in the same cycle as a new edge → io_level stays 16, io_overflow_cnt unchanged, the newest entry appears at the tail after 16 pops.
5. Mask bit 0 off, toggle bit 0, hold io_arm = 0 and toggle bit 1, then re-arm with bit 1 still high → no entries; io_ts_now frozen while disarmed.
6. Pulse io_clr mid-stream with io_level = 5 and io_overflow_cnt = 2 → next cycle all three counters are 0, io_rd_valid = 0, and an edge in the clr cycle is not logged.
